// File: rtl/image_mem_arbiter_pkg.sv
// Shared types and defaults for the image RAM arbiter: owner tags carried
// alongside each RAM read, default widths and the fixed read latency.
package image_mem_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned ADDR_W_DEF = 17;
    localparam int unsigned RD_LAT     = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/image_mem_arbiter_rd_tag_pipe.sv
// Owner-tag delay line matching the command register plus the RAM read stage,
// so the tag at the output lines up with the data on RAM DO.
module rd_tag_pipe
    import image_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t stage_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: display reads have priority, the host is
// guaranteed a slot after MAX_WAIT lost contended cycles.
module image_mem_arbiter
    import image_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_di_q, mem_di_d;
    owner_t            tag_d, tag_rtn;
    logic              host_force;

    assign host_force = (wait_cnt_q == WAIT_MAX);
    assign disp_gnt   = disp_req && !(host_req && host_force);
    assign host_gnt   = host_req && (!disp_req || host_force);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (host_gnt) begin
            wait_cnt_d = '0;
        end else if (host_req && !host_force) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Writes carry no tag: the RAM's write-through echo on DO must never surface.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        tag_d      = OWN_NONE;
        if (host_gnt) begin
            mem_addr_d = host_addr;
            mem_we_d   = host_we;
            if (host_we) begin
                mem_di_d = host_wdata;
            end else begin
                tag_d = OWN_HOST;
            end
        end else if (disp_gnt) begin
            mem_addr_d = disp_addr;
            tag_d      = OWN_DISP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_di_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
        end
    end

    rd_tag_pipe u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_d),
        .tag_o (tag_rtn)
    );

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_di      = mem_di_q;
    assign disp_rvalid = (tag_rtn == OWN_DISP);
    assign host_rvalid = (tag_rtn == OWN_HOST);
    assign disp_rdata  = disp_rvalid ? mem_do : '0;
    assign host_rdata  = host_rvalid ? mem_do : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a behavioural 1-cycle-read RAM;
// unwritten RAM words read as 0xD00000 | addr[9:0].
module tb_image_mem_arbiter;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_req, disp_gnt, disp_rvalid;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          host_req, host_we, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    image_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_di      (mem_di),
        .mem_do      (mem_do)
    );

    logic [DW-1:0] ram [0:1023];
    logic [1023:0] wr_mask = '0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 24'hD00000 | DW'(a[9:0]);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[9:0]]     <= mem_di;
            wr_mask[mem_addr[9:0]] <= 1'b1;
            mem_do                 <= mem_di;
        end else begin
            mem_do <= wr_mask[mem_addr[9:0]] ? ram[mem_addr[9:0]] : pat(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        rst_n = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #2;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_di", mem_di, 0);
        chk("rst_disp_rvalid", disp_rvalid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_disp_rdata", disp_rdata, 0);
        next_cycle();
        rst_n = 1'b1;

        // Host only: write then read back
        next_cycle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 'h10; host_wdata = 'hA1B2C3;
        @(negedge clk);
        chk("t1_wr_hgnt", host_gnt, 1);
        chk("t1_wr_dgnt", disp_gnt, 0);
        next_cycle();
        host_we = 1'b0;
        @(negedge clk);
        chk("t1_rd_hgnt", host_gnt, 1);
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 'h10);
        chk("t1_mem_di", mem_di, 'hA1B2C3);
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        chk("t1_we_off", mem_we, 0);
        chk("t1_no_rv_wr", host_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("t1_hrvalid", host_rvalid, 1);
        chk("t1_hrdata", host_rdata, 'hA1B2C3);
        chk("t1_drvalid", disp_rvalid, 0);

        // Display stream, addresses 0..15
        for (int c = 0; c < 18; c++) begin
            next_cycle();
            disp_req  = (c < 16);
            disp_addr = AW'(c);
            @(negedge clk);
            if (c < 16) chk("t2_dgnt", disp_gnt, 1);
            if (c >= 2) begin
                chk("t2_drvalid", disp_rvalid, 1);
                chk("t2_drdata", disp_rdata, 32'hD00000 + 32'(c - 2));
            end else begin
                chk("t2_drvalid_lat", disp_rvalid, 0);
            end
            chk("t2_hrvalid", host_rvalid, 0);
        end

        // Contention with held display stream; host forced in on 9th cycle
        idx = 0;
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            disp_req  = (c <= 10);
            disp_addr = AW'(32'h20 + idx);
            host_req  = (c <= 8);
            host_we   = 1'b0;
            host_addr = 'h10;
            @(negedge clk);
            if (c <= 10) begin
                chk("t3_hgnt", host_gnt, (c == 8));
                chk("t3_dgnt", disp_gnt, (c != 8));
            end
            if (c == 8) chk("t3_wait_max", dut.wait_cnt_q, 8);
            if (c == 9) chk("t3_wait_clr", dut.wait_cnt_q, 0);
            chk("t3_hrvalid", host_rvalid, (c == 10));
            chk("t3_drvalid", disp_rvalid, ((c >= 2 && c <= 9) || c >= 11));
            if (c == 10) chk("t3_hrdata", host_rdata, 'hA1B2C3);
            if ((c >= 2 && c <= 9) || c >= 11)
                chk("t3_drdata", disp_rdata, 32'hD00020 + 32'(c <= 9 ? c - 2 : c - 3));
            if (disp_gnt) idx++;
        end

        // Simultaneous host write and display read to the same address
        next_cycle();
        disp_req = 1'b1; disp_addr = 'h30;
        host_req = 1'b1; host_we = 1'b1; host_addr = 'h30; host_wdata = 'h5A5A5A;
        @(negedge clk);
        chk("t4_dgnt", disp_gnt, 1);
        chk("t4_hgnt_denied", host_gnt, 0);
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        chk("t4_hgnt_late", host_gnt, 1);
        chk("t4_no_write", mem_we, 0);
        chk("t4_disp_addr", mem_addr, 'h30);
        next_cycle();
        host_we = 1'b0;
        @(negedge clk);
        chk("t4_rd_hgnt", host_gnt, 1);
        chk("t4_write", mem_we, 1);
        chk("t4_wdata", mem_di, 'h5A5A5A);
        chk("t4_drvalid", disp_rvalid, 1);
        chk("t4_drdata_old", disp_rdata, 'hD00030);
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        chk("t4_no_rv_h", host_rvalid, 0);
        chk("t4_no_rv_d", disp_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("t4_hrvalid", host_rvalid, 1);
        chk("t4_hrdata_new", host_rdata, 'h5A5A5A);

        // Reset one cycle after a display grant
        next_cycle();
        disp_req = 1'b1; disp_addr = 'h5;
        @(negedge clk);
        chk("t5_dgnt", disp_gnt, 1);
        next_cycle();
        disp_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_di", mem_di, 0);
        chk("t5_rst_drvalid", disp_rvalid, 0);
        chk("t5_rst_hrvalid", host_rvalid, 0);
        chk("t5_rst_drdata", disp_rdata, 0);
        chk("t5_rst_hrdata", host_rdata, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_dropped", disp_rvalid, 0);
        next_cycle();
        disp_req = 1'b1; disp_addr = 'h3;
        @(negedge clk);
        chk("t5_post_dgnt", disp_gnt, 1);
        chk("t5_post_quiet", disp_rvalid, 0);
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        chk("t5_post_addr", mem_addr, 'h3);
        next_cycle();
        @(negedge clk);
        chk("t5_post_rvalid", disp_rvalid, 1);
        chk("t5_post_rdata", disp_rdata, 'hD00003);

        // Idle gaps between requests
        next_cycle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 'h40; host_wdata = 'h123456;
        @(negedge clk);
        chk("t6_hgnt", host_gnt, 1);
        next_cycle();
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        chk("t6_idle_hgnt", host_gnt, 0);
        chk("t6_idle_dgnt", disp_gnt, 0);
        chk("t6_we", mem_we, 1);
        next_cycle();
        disp_req = 1'b1; disp_addr = 'h40;
        @(negedge clk);
        chk("t6_dgnt", disp_gnt, 1);
        chk("t6_we_off", mem_we, 0);
        chk("t6_echo_hidden", host_rvalid, 0);
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        chk("t6_gap_we", mem_we, 0);
        chk("t6_gap_drv", disp_rvalid, 0);
        chk("t6_gap_hrv", host_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("t6_drvalid", disp_rvalid, 1);
        chk("t6_drdata", disp_rdata, 'h123456);
        chk("t6_hrv_quiet", host_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("t6_end_drv", disp_rvalid, 0);
        chk("t6_end_we", mem_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
Shares the single-port inferred image RAM (24-bit pixels, 1-cycle registered read) between two requesters. The display scan-out reader has priority; the host port (loader/processing engine) gets reads and writes. A starvation counter guarantees the host a slot within MAX_WAIT contended cycles. The block registers the RAM command, tags each read, and routes the returned data to the owner.

Parameters:
DATA_W, 24, pixel/RAM word width
ADDR_W, 17, RAM address width (320x240 frame fits)
MAX_WAIT, 8, contended cycles the host may lose before a forced grant (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle (combinational)
disp_rvalid  out  1  disp_rdata valid
disp_rdata  out  DATA_W  display read data
host_req  in  1  host request
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host request accepted this cycle (combinational)
host_rvalid  out  1  host_rdata valid (reads only)
host_rdata  out  DATA_W  host read data
mem_we  out  1  to RAM write_enable (registered)
mem_addr  out  ADDR_W  to RAM addr (registered)
mem_di  out  DATA_W  to RAM DI (registered)
mem_do  in  DATA_W  from RAM DO

Behaviour:
- Reset (async, rst_n=0): mem_we=0, mem_addr=0, mem_di=0, both rvalid=0, both rdata=0, starvation counter=0, tag pipeline cleared. In-flight reads at reset are dropped; no rvalid is produced for them after release.
- Grant (combinational, cycle N): only one requester -> it is granted. Both requesting -> display granted unless wait_cnt==MAX_WAIT, then host granted. A gnt is an acceptance; the requester may change req/addr in the next cycle.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle with host_req=1 and host_gnt=0; clears to 0 on any host_gnt; holds when host_req=0.
- Command register (edge ending N): on any grant, mem_addr<=granted addr, mem_we<=host_we when the host is granted else 0, mem_di<=host_wdata when a host write is granted. With no grant: mem_we<=0, mem_addr/mem_di hold. The RAM never sees a write outside a granted host write.
- Tag pipeline: stage1 tag {NONE,DISP,HOST} loaded at edge ending N (HOST only for host reads; writes tag NONE). Stage2 loaded from stage1 at edge ending N+1. RAM DO valid during N+2.
- Return: during N+2, rvalid of the stage2 owner=1 (combinational from stage2 tag). rdata=mem_do passed through, qualified by rvalid. Read latency is 2 cycles from gnt to rvalid, fixed, and back-to-back grants give 1 result per cycle in order.
- Write-through DO (RAM echoes DI on write) is ignored: writes never raise rvalid.
- Host read after host write to the same address in consecutive grants returns the new data (RAM ordering). The block does no extra hazard logic.
- Idle (no req): no grants, no RAM write, rvalid=0.

Decomposition:
- Package image_mem_pkg: owner_t enum (OWN_NONE, OWN_DISP, OWN_HOST), DATA_W/ADDR_W defaults, read latency constant RD_LAT=2.
- One sub-module, rd_tag_pipe: 2-stage owner_t shift register with async reset, giving the stage2 tag. Grant logic, counter and command register stay in the top.

Test Plan:
- Host only: host write addr 0x00010 data 0xA1B2C3, then read 0x00010 -> host_gnt both cycles, mem_we=1 one cycle, host_rvalid 2 cycles after read gnt with 0xA1B2C3, disp_rvalid stays 0.
- Display stream: disp_req held, addrs 0..15, one per cycle -> disp_gnt every cycle, 16 disp_rvalid pulses starting 2 cycles after the first gnt, data in address order.
- Contention/starvation (MAX_WAIT=8): disp_req held continuously plus a host read -> host denied 8 cycles, granted on 9th, wait_cnt back to 0, display loses exactly that one cycle, and each rvalid goes to the correct owner.
- Simultaneous host write and display read to same addr with wait_cnt<MAX_WAIT -> display granted, no RAM write that cycle, host write lands when later granted.
- Reset mid-operation: assert rst_n=0 one cycle after a display gnt -> all outputs 0 immediately (async), no rvalid after release, and the first post-reset grant behaves normally.
- Idle gaps: alternating req/no-req on both ports -> mem_we only on granted host writes, no spurious rvalid.
